// File: rtl/ysyx_23060191_ifu_fetch.sv
// Instruction fetch controller: owns the architectural PC, issues one
// instruction-memory read at a time and hands the fetched word to the IDU.
// EXU redirects retarget the PC at any point; a response that belongs to a
// pre-redirect address is dropped instead of being presented.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. valid is never withdrawn before its transfer except on reset or
// redirect. The payload stays stable while valid waits for ready, except
// mem_raddr, which follows a redirect because memory samples the address
// only on a handshake.
module ysyx_23060191_ifu_fetch #(
    parameter int                   CPU_WIDTH = 32,
    parameter logic [CPU_WIDTH-1:0] RESET_PC  = 32'h8000_0000,
    parameter int                   CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic                 mem_req_valid,
    input  logic                 mem_req_ready,
    output logic [CPU_WIDTH-1:0] mem_raddr,
    input  logic                 mem_resp_valid,
    input  logic [CPU_WIDTH-1:0] mem_rdata,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CPU_WIDTH-1:0] out_pc,
    output logic [CPU_WIDTH-1:0] out_inst,
    input  logic                 redirect_valid,
    input  logic [CPU_WIDTH-1:0] redirect_pc,
    output logic [CNT_WIDTH-1:0] fetch_cnt
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [CPU_WIDTH-1:0] pc;
    logic [CPU_WIDTH-1:0] inst_q;
    logic                 discard;
    logic [CPU_WIDTH-1:0] redirect_tgt;
    logic                 req_fire;
    logic                 out_fire;
    logic                 unused_redirect_lsbs;

    // Instructions are word aligned, so the two low target bits are dropped.
    assign redirect_tgt         = {redirect_pc[CPU_WIDTH-1:2], 2'b00};
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    assign req_fire  = mem_req_valid && mem_req_ready;
    assign out_fire  = out_valid && out_ready;
    assign mem_raddr = pc;
    assign out_pc    = pc;
    assign out_inst  = inst_q;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_REQ;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state selection; a redirect always pulls the FSM back towards REQ
    // unless a request is still in flight and must be drained.
    always_comb begin
        state_nxt = state;
        case (state)
            S_REQ: begin
                if (req_fire) state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (mem_resp_valid) begin
                    state_nxt = (discard || redirect_valid) ? S_REQ : S_HOLD;
                end
            end
            S_HOLD: begin
                if (redirect_valid || out_fire) state_nxt = S_REQ;
            end
            default: state_nxt = S_REQ;
        endcase
    end

    // Handshake valids, forced low while reset is held.
    always_comb begin
        mem_req_valid = 1'b0;
        out_valid     = 1'b0;
        if (rst_n) begin
            mem_req_valid = (state == S_REQ);
            out_valid     = (state == S_HOLD);
        end
    end

    // PC, squash flag, captured instruction and delivered-instruction count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc        <= RESET_PC;
            discard   <= 1'b0;
            inst_q    <= '0;
            fetch_cnt <= '0;
        end else begin
            case (state)
                S_REQ: begin
                    if (redirect_valid) pc <= redirect_tgt;
                    // The request just issued used the old PC: drop its data.
                    if (redirect_valid && req_fire) discard <= 1'b1;
                end
                S_WAIT: begin
                    if (mem_resp_valid) begin
                        if (!discard && !redirect_valid) begin
                            inst_q <= mem_rdata;
                        end else begin
                            discard <= 1'b0;
                            if (redirect_valid) pc <= redirect_tgt;
                        end
                    end else if (redirect_valid) begin
                        pc      <= redirect_tgt;
                        discard <= 1'b1;
                    end
                end
                S_HOLD: begin
                    // Redirect wins over a simultaneous IDU accept.
                    if (redirect_valid) begin
                        pc <= redirect_tgt;
                    end else if (out_fire) begin
                        pc        <= pc + CPU_WIDTH'(4);
                        fetch_cnt <= fetch_cnt + CNT_WIDTH'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // A read response is only legal while a request is outstanding.
    resp_only_in_wait: assert property (
        @(posedge clk) disable iff (!rst_n) mem_resp_valid |-> state == S_WAIT
    );

endmodule

// File: doc/ysyx_23060191_ifu_fetch.md
Name: ysyx_23060191_ifu_fetch

Overview:
Fetch controller directly upstream of the instruction-memory read port. Holds the architectural PC and issues one read request at a time over a valid/ready request channel. Captures the returned instruction and presents it to the IDU over a valid/ready channel. Handles branch/jump redirects from the EXU, including squashing an in-flight response.

Parameters:
CPU_WIDTH, 32, width of PC, address and instruction
RESET_PC, 32'h8000_0000, PC loaded on reset
CNT_WIDTH, 32, width of the delivered-instruction counter

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  synchronous active-low reset
mem_req_valid  output  1  read request valid
mem_req_ready  input  1  memory accepts request this cycle
mem_raddr  output  CPU_WIDTH  fetch address (current PC)
mem_resp_valid  input  1  read data valid, one cycle per accepted request
mem_rdata  input  CPU_WIDTH  instruction word
out_valid  output  1  instruction available to IDU
out_ready  input  1  IDU accepts instruction
out_pc  output  CPU_WIDTH  PC of presented instruction
out_inst  output  CPU_WIDTH  presented instruction
redirect_valid  input  1  EXU redirect strobe (one cycle)
redirect_pc  input  CPU_WIDTH  redirect target
fetch_cnt  output  CNT_WIDTH  count of instructions handed to IDU

Behaviour:
- Reset: clk is the only clock. rst_n is synchronous and active-low. While rst_n=0 at a rising edge: pc<=RESET_PC, state<=REQ, discard<=0, inst_q<=0, fetch_cnt<=0. While in reset, mem_req_valid=0 and out_valid=0 combinationally. Memory shares rst_n, so no stale response survives a reset.
- Outputs: mem_raddr=pc, out_pc=pc, out_inst=inst_q. mem_req_valid=1 only in REQ. out_valid=1 only in HOLD.
- redirect_pc[1:0] is forced to 2'b00 when loaded into pc.
- FSM states: REQ, WAIT, HOLD.
- REQ:
  - mem_req_valid && mem_req_ready -> WAIT.
  - redirect_valid without handshake: pc<=redirect_pc and stay REQ. mem_raddr may change while valid; memory samples the address only on handshake.
  - redirect_valid with handshake in the same cycle: pc<=redirect_pc, discard<=1, go WAIT.
- WAIT:
  - mem_resp_valid && !discard && !redirect_valid: inst_q<=mem_rdata, go HOLD.
  - mem_resp_valid && (discard || redirect_valid): drop the data, discard<=0, pc<=redirect_pc if redirect_valid, go REQ.
  - redirect_valid without response: pc<=redirect_pc, discard<=1, stay WAIT.
  - A response may arrive any number of cycles after the request, including the cycle immediately after. Zero-cycle (same-cycle) responses are not supported.
- HOLD:
  - out_valid && out_ready && !redirect_valid: pc<=pc+4 (modulo 2^CPU_WIDTH, 0xFFFF_FFFC wraps to 0), fetch_cnt<=fetch_cnt+1 (wraps), go REQ.
  - redirect_valid: out_valid deasserts next cycle, pc<=redirect_pc, go REQ. Redirect wins over a simultaneous out_ready: the instruction is not counted and the IDU must discard it on redirect.
  - out_pc and out_inst stay stable while out_valid=1 and out_ready=0.
- Throughput: at most one outstanding request. Best-case loop is REQ->WAIT->HOLD = 3 cycles per instruction with ready memory and IDU.
- Protocol errors (simulation assertions):
  - mem_resp_valid in REQ or HOLD is ignored.
  - mem_rdata is sampled only in WAIT.

Test Plan:
- Reset then free-run (mem_req_ready=1, 1-cycle response, out_ready=1, rdata=addr^32'hFFFF_FFFF): out_pc sequence 0x8000_0000, 0x8000_0004, 0x8000_0008. out_inst matches rdata. fetch_cnt=3 after third handoff. Each instruction takes 3 cycles.
- Backpressure: out_ready=0 for 5 cycles in HOLD -> out_valid held with unchanged out_pc/out_inst, no new mem_req_valid. Release -> next request at pc+4.
- Redirect in WAIT (response delayed 4 cycles, redirect_pc=0x8000_0100 at cycle 2) -> returned word dropped, next mem_raddr=0x8000_0100, no out_valid for the squashed fetch, fetch_cnt unchanged.
- Redirect same cycle as request handshake, and same cycle as out_ready in HOLD (target 0x8000_0203) -> pc becomes 0x8000_0200, squashed response never appears on out_inst, fetch_cnt not incremented.
- Stalling memory: mem_req_ready=0 for 3 cycles with redirect to 0x8000_0040 mid-stall -> mem_raddr switches to 0x8000_0040 while mem_req_valid stays 1. Accepted address is 0x8000_0040.
- Reset asserted during WAIT and during HOLD -> next cycle mem_req_valid=0, out_valid=0. After release, first request at 0x8000_0000 and fetch_cnt=0. Wrap check: redirect to 0xFFFF_FFFC, consume -> next mem_raddr=0x0000_0000.
